// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt sequencer for the M stage: arbitrates interrupts, exceptions and eret,
// holds SR/Cause/EPC/PRId, and drives the flush/redirect handshake plus mfc0/mtc0 access.
module exc_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL     = 32'h0000_0007
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_pc,
   input  logic [4:0]  M_exccode,
   input  logic        M_bd,
   input  logic        M_eret,
   input  logic [5:0]  hw_int,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        exc_req,
   output logic        eret_req,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc_out,
   output logic        exl_out
);

   localparam int unsigned IM_W   = 6;
   localparam int unsigned CODE_W = 5;
   localparam logic [4:0]  ADDR_SR    = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE = 5'd13;
   localparam logic [4:0]  ADDR_EPC   = 5'd14;
   localparam logic [4:0]  ADDR_PRID  = 5'd15;
   localparam logic [31:0] EPC_MASK   = 32'hFFFF_FFFC;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [IM_W-1:0]     sr_im_q, sr_im_d;
   logic                sr_exl_q, sr_exl_d;
   logic                sr_ie_q, sr_ie_d;
   logic                cause_bd_q, cause_bd_d;
   logic [IM_W-1:0]     cause_ip_q, cause_ip_d;
   logic [CODE_W-1:0]   cause_code_q, cause_code_d;
   logic [31:0]         epc_q, epc_d;

   logic                int_pend;
   logic                exc_pend;
   logic [31:0]         epc_src;

   // State and CP0 register bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         sr_im_q      <= '0;
         sr_exl_q     <= 1'b0;
         sr_ie_q      <= 1'b0;
         cause_bd_q   <= 1'b0;
         cause_ip_q   <= '0;
         cause_code_q <= '0;
         epc_q        <= '0;
      end else begin
         state_q      <= state_d;
         sr_im_q      <= sr_im_d;
         sr_exl_q     <= sr_exl_d;
         sr_ie_q      <= sr_ie_d;
         cause_bd_q   <= cause_bd_d;
         cause_ip_q   <= cause_ip_d;
         cause_code_q <= cause_code_d;
         epc_q        <= epc_d;
      end
   end

   // Arbitration: interrupt > exception > eret > mtc0; HOLD covers the flushed bubble
   always_comb begin
      state_d      = ST_RUN;
      sr_im_d      = sr_im_q;
      sr_exl_d     = sr_exl_q;
      sr_ie_d      = sr_ie_q;
      cause_bd_d   = cause_bd_q;
      cause_ip_d   = hw_int;
      cause_code_d = cause_code_q;
      epc_d        = epc_q;
      exc_req      = 1'b0;
      eret_req     = 1'b0;
      redirect_pc  = '0;

      int_pend = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
      exc_pend = (M_exccode != '0) & ~sr_exl_q;
      epc_src  = M_bd ? (M_pc - 32'd4) : M_pc;

      case (state_q)
         ST_RUN: begin
            if (int_pend || exc_pend) begin
               exc_req      = 1'b1;
               redirect_pc  = HANDLER_ADDR;
               cause_code_d = int_pend ? '0 : M_exccode;
               cause_bd_d   = M_bd;
               epc_d        = epc_src & EPC_MASK;
               sr_exl_d     = 1'b1;
               state_d      = ST_HOLD;
            end else if (M_eret) begin
               eret_req    = 1'b1;
               redirect_pc = epc_q;
               sr_exl_d    = 1'b0;
               state_d     = ST_HOLD;
            end else if (cp0_we) begin
               case (cp0_addr)
                  ADDR_SR: begin
                     sr_im_d  = cp0_wdata[15:10];
                     sr_exl_d = cp0_wdata[1];
                     sr_ie_d  = cp0_wdata[0];
                  end
                  ADDR_EPC: epc_d = cp0_wdata & EPC_MASK;
                  default: ;
               endcase
            end
         end
         ST_HOLD: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // mfc0 read port, no forwarding of a same-cycle mtc0
   always_comb begin
      case (cp0_addr)
         ADDR_SR:    cp0_rdata = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
         ADDR_CAUSE: cp0_rdata = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_code_q, 2'b0};
         ADDR_EPC:   cp0_rdata = epc_q;
         ADDR_PRID:  cp0_rdata = PRID_VAL;
         default:    cp0_rdata = '0;
      endcase
   end

   assign epc_out = epc_q;
   assign exl_out = sr_exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized run against
// a register-word reference model of the CP0 behaviour.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] M_pc;
   logic [4:0]  M_exccode;
   logic        M_bd;
   logic        M_eret;
   logic [5:0]  hw_int;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] redirect_pc;
   logic [31:0] epc_out;
   logic        exl_out;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] HANDLER = 32'h0000_4180;
   localparam logic [31:0] PRID    = 32'h0000_0007;

   exc_ctrl dut (
      .clk(clk), .reset(reset), .M_pc(M_pc), .M_exccode(M_exccode), .M_bd(M_bd),
      .M_eret(M_eret), .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_req(exc_req), .eret_req(eret_req),
      .redirect_pc(redirect_pc), .epc_out(epc_out), .exl_out(exl_out)
   );

   always #5 clk = ~clk;

   task automatic idle();
      M_pc = '0; M_exccode = '0; M_bd = 1'b0; M_eret = 1'b0; hw_int = '0;
      cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      #2;
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL reset_exc_req got %0b want 0", exc_req); end
      checks++; if (eret_req !== 1'b0) begin errors++; $display("FAIL reset_eret_req got %0b want 0", eret_req); end
      checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want 0", epc_out); end
      checks++; if (exl_out !== 1'b0) begin errors++; $display("FAIL reset_exl got %0b want 0", exl_out); end
      cp0_addr = 5'd12; #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_sr got %h want 0", cp0_rdata); end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_cause got %h want 0", cp0_rdata); end
      cp0_addr = 5'd15; #1;
      checks++; if (cp0_rdata !== PRID) begin errors++; $display("FAIL reset_prid got %h want %h", cp0_rdata, PRID); end
      reset = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      M_exccode = 5'd12; M_pc = 32'h3008; M_bd = 1'b0;
      #2;
      checks++; if (exc_req !== 1'b1) begin errors++; $display("FAIL ov_exc_req got %0b want 1", exc_req); end
      checks++; if (redirect_pc !== HANDLER) begin errors++; $display("FAIL ov_redirect got %h want %h", redirect_pc, HANDLER); end
      tick();
      idle();
      cp0_addr = 5'd13;
      #2;
      checks++; if (cp0_rdata !== 32'h0000_0030) begin errors++; $display("FAIL ov_cause got %h want 00000030", cp0_rdata); end
      checks++; if (epc_out !== 32'h3008) begin errors++; $display("FAIL ov_epc got %h want 00003008", epc_out); end
      checks++; if (exl_out !== 1'b1) begin errors++; $display("FAIL ov_exl got %0b want 1", exl_out); end
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL ov_hold_exc_req got %0b want 0", exc_req); end
      tick();
   endtask

   task automatic test_delay_slot();
      do_reset();
      M_exccode = 5'd4; M_pc = 32'h3010; M_bd = 1'b1;
      #2;
      checks++; if (exc_req !== 1'b1) begin errors++; $display("FAIL bd_exc_req got %0b want 1", exc_req); end
      tick();
      idle();
      cp0_addr = 5'd13;
      #2;
      checks++; if (epc_out !== 32'h300C) begin errors++; $display("FAIL bd_epc got %h want 0000300c", epc_out); end
      checks++; if (cp0_rdata !== 32'h8000_0010) begin errors++; $display("FAIL bd_cause got %h want 80000010", cp0_rdata); end
      tick();
   endtask

   task automatic test_interrupt();
      do_reset();
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
      #2;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL int_no_forward got %h want 0", cp0_rdata); end
      tick();
      idle();
      cp0_addr = 5'd12;
      #2;
      checks++; if (cp0_rdata !== 32'h0000_0401) begin errors++; $display("FAIL int_sr got %h want 00000401", cp0_rdata); end
      hw_int = 6'b000001; M_exccode = 5'd10; M_pc = 32'h3020;
      #2;
      checks++; if (exc_req !== 1'b1) begin errors++; $display("FAIL int_exc_req got %0b want 1", exc_req); end
      tick();
      idle();
      cp0_addr = 5'd13;
      #2;
      checks++; if (cp0_rdata !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h want 00000400", cp0_rdata); end
      tick();
   endtask

   task automatic test_exl_eret();
      do_reset();
      cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
      tick();
      idle();
      M_exccode = 5'd12; M_pc = 32'h2000;
      tick();
      idle();
      tick();
      M_exccode = 5'd10; hw_int = 6'b000001;
      #2;
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL exl_mask got %0b want 0", exc_req); end
      tick();
      M_exccode = '0; M_eret = 1'b1;
      #2;
      checks++; if (eret_req !== 1'b1) begin errors++; $display("FAIL eret_req got %0b want 1", eret_req); end
      checks++; if (redirect_pc !== 32'h2000) begin errors++; $display("FAIL eret_redirect got %h want 00002000", redirect_pc); end
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL eret_exc_req got %0b want 0", exc_req); end
      tick();
      M_eret = 1'b0;
      #2;
      checks++; if (exl_out !== 1'b0) begin errors++; $display("FAIL eret_exl got %0b want 0", exl_out); end
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL eret_hold_exc_req got %0b want 0", exc_req); end
      tick();
      #2;
      checks++; if (exc_req !== 1'b1) begin errors++; $display("FAIL eret_then_int got %0b want 1", exc_req); end
      tick();
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      M_exccode = 5'd12; M_pc = 32'h6000; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
      tick();
      idle();
      M_exccode = 5'd5;
      #2;
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL b2b_hold_exc_req got %0b want 0", exc_req); end
      checks++; if (epc_out !== 32'h6000) begin errors++; $display("FAIL b2b_epc got %h want 00006000", epc_out); end
      tick();
      idle();
   endtask

   task automatic test_boundaries();
      do_reset();
      M_exccode = 5'd5; M_pc = 32'h0; M_bd = 1'b1;
      tick();
      idle();
      #2;
      checks++; if (epc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc got %h want fffffffc", epc_out); end
      do_reset();
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1237;
      tick();
      cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFE;
      tick();
      cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      tick();
      cp0_addr = 5'd15;
      tick();
      cp0_we = 1'b0; cp0_addr = 5'd14;
      #2;
      checks++; if (cp0_rdata !== 32'h1234) begin errors++; $display("FAIL mtc0_epc got %h want 00001234", cp0_rdata); end
      cp0_addr = 5'd12; #1;
      checks++; if (cp0_rdata !== 32'h0000_FC02) begin errors++; $display("FAIL mtc0_sr got %h want 0000fc02", cp0_rdata); end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL mtc0_cause got %h want 0", cp0_rdata); end
      cp0_addr = 5'd15; #1;
      checks++; if (cp0_rdata !== PRID) begin errors++; $display("FAIL mtc0_prid got %h want %h", cp0_rdata, PRID); end
      cp0_addr = 5'd3; #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", cp0_rdata); end
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      M_exccode = 5'd12; M_pc = 32'h7000;
      tick();
      idle();
      #2;
      reset = 1'b1;
      #1;
      checks++; if (exl_out !== 1'b0) begin errors++; $display("FAIL arst_exl got %0b want 0", exl_out); end
      checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL arst_epc got %h want 0", epc_out); end
      checks++; if (exc_req !== 1'b0) begin errors++; $display("FAIL arst_exc_req got %0b want 0", exc_req); end
      cp0_addr = 5'd13; #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL arst_cause got %h want 0", cp0_rdata); end
      reset = 1'b0;
      M_exccode = 5'd12; M_pc = 32'h7100;
      #1;
      checks++; if (exc_req !== 1'b1) begin errors++; $display("FAIL arst_run got %0b want 1", exc_req); end
      tick();
      idle();
      tick();
   endtask

   // Reference model: whole CP0 words plus a one-cycle flush shadow
   logic [31:0] m_sr, m_cause, m_epc;
   bit          m_shadow;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_random();
      bit          intp, excp, take, eret;
      logic [31:0] want_redir;
      do_reset();
      m_sr = '0; m_cause = '0; m_epc = '0; m_shadow = 1'b0;
      for (int n = 0; n < 400; n++) begin
         M_pc      = $urandom;
         M_bd      = 1'($urandom_range(0, 1));
         M_exccode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3) * 2 + 4) : 5'd0;
         if (M_exccode == 5'd6) M_exccode = 5'd10;
         if (M_exccode == 5'd8) M_exccode = 5'd12;
         M_eret    = ($urandom_range(0, 4) == 0);
         hw_int    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         cp0_we    = ($urandom_range(0, 3) == 0);
         cp0_addr  = 5'($urandom_range(10, 16));
         cp0_wdata = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_FC01) : $urandom;
         #2;
         intp = (((32'(hw_int) << 10) & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
         excp = (M_exccode != 0) && !m_sr[1];
         take = !m_shadow && (intp || excp);
         eret = !m_shadow && !take && M_eret;
         want_redir = take ? HANDLER : (eret ? m_epc : 32'h0);
         checks++; if (exc_req !== take) begin errors++; $display("FAIL rnd_exc_req n=%0d got %0b want %0b", n, exc_req, take); end
         checks++; if (eret_req !== eret) begin errors++; $display("FAIL rnd_eret_req n=%0d got %0b want %0b", n, eret_req, eret); end
         checks++; if (redirect_pc !== want_redir) begin errors++; $display("FAIL rnd_redirect n=%0d got %h want %h", n, redirect_pc, want_redir); end
         checks++; if (cp0_rdata !== m_read(cp0_addr)) begin errors++; $display("FAIL rnd_rdata n=%0d addr=%0d got %h want %h", n, cp0_addr, cp0_rdata, m_read(cp0_addr)); end
         checks++; if (epc_out !== m_epc) begin errors++; $display("FAIL rnd_epc n=%0d got %h want %h", n, epc_out, m_epc); end
         checks++; if (exl_out !== m_sr[1]) begin errors++; $display("FAIL rnd_exl n=%0d got %0b want %0b", n, exl_out, m_sr[1]); end
         @(posedge clk);
         m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
         if (m_shadow) begin
            m_shadow = 1'b0;
         end else if (take) begin
            m_cause  = (m_cause & 32'h0000_FC00) | (32'(M_bd) << 31) | (intp ? 32'h0 : (32'(M_exccode) << 2));
            m_epc    = ((M_pc - (M_bd ? 32'd4 : 32'd0)) / 4) * 4;
            m_sr     = m_sr | 32'h2;
            m_shadow = 1'b1;
         end else if (eret) begin
            m_sr     = m_sr & ~32'h2;
            m_shadow = 1'b1;
         end else if (cp0_we && cp0_addr == 5'd12) begin
            m_sr = cp0_wdata & 32'h0000_FC03;
         end else if (cp0_we && cp0_addr == 5'd14) begin
            m_epc = (cp0_wdata / 4) * 4;
         end
         #1;
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_overflow();
      test_delay_slot();
      test_interrupt();
      test_exl_eret();
      test_back_to_back();
      test_boundaries();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
